snoop_window_ctrl: RTL and testbench

Sequencer for one packet-snooping measurement unit. Opens a measurement window of programmed length by driving `measure`, then collects the three 64-bit count words (cycle, flit, packet) that the snooper emits after the window closes. It merges them into one 3-beat AXI-Stream result record for the host/DMA path. It sits between the control registers and the snooper and is the snooper's only source of `measure`.

---
 rtl/snoop_window_ctrl_pkg.sv | 24 ++
 rtl/snoop_window_ctrl_capture_slot.sv | 37 +++
 rtl/snoop_window_ctrl.sv | 179 +++++++++++++++++
 tb/tb_snoop_window_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_window_ctrl_pkg.sv
// Shared types and constants for the snoop window sequencer and its capture slots.
package snoop_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_COLLECT = 2'd2,
    ST_EMIT    = 2'd3
  } state_t;

  localparam int unsigned RESULT_BEATS = 3;
  localparam int unsigned WORD_W       = 64;

  typedef logic [1:0] beat_idx_t;

  localparam beat_idx_t         LAST_BEAT    = beat_idx_t'(RESULT_BEATS - 1);
  localparam logic [WORD_W-1:0] TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              last;
  } result_beat_t;

endpackage

// File: rtl/snoop_window_ctrl_capture_slot.sv
// count_capture_slot: holds one snooper count word; ready until captured, or filled on timeout.
module count_capture_slot
  import snoop_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              areset,
  input  logic              clear,
  input  logic              collect_en,
  input  logic              force_fill,
  input  logic              tvalid,
  input  logic [WORD_W-1:0] tdata,
  output logic              tready_c,
  output logic              take_c,
  output logic              captured,
  output logic [WORD_W-1:0] word
);

  assign tready_c = collect_en & ~captured;
  assign take_c   = tvalid & tready_c;

  // A real word on the timeout cycle wins over the fill value.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      captured <= 1'b0;
      word     <= '0;
    end else if (clear) begin
      captured <= 1'b0;
    end else if (take_c) begin
      captured <= 1'b1;
      word     <= tdata;
    end else if (force_fill && !captured) begin
      captured <= 1'b1;
      word     <= TIMEOUT_FILL;
    end
  end

endmodule

// File: rtl/snoop_window_ctrl.sv
// snoop_window_ctrl: opens a measure window, gathers the three count words and emits a 3-beat record.
// Optional SNOOP_CTRL_AUTO_REARM_EN adds a rearm input that restarts the window straight from EMIT.
module snoop_window_ctrl
  import snoop_ctrl_pkg::*;
#(
  parameter int unsigned WIN_WIDTH       = 32,
  parameter int unsigned COLLECT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 start,
  input  logic [WIN_WIDTH-1:0] window_len,
  input  logic                 abort,
  output logic                 measure,
  input  logic [WORD_W-1:0]    cycle_count_TDATA,
  input  logic                 cycle_count_TVALID,
  output logic                 cycle_count_TREADY,
  input  logic [WORD_W-1:0]    flit_count_TDATA,
  input  logic                 flit_count_TVALID,
  output logic                 flit_count_TREADY,
  input  logic [WORD_W-1:0]    packet_count_TDATA,
  input  logic                 packet_count_TVALID,
  output logic                 packet_count_TREADY,
  output logic [WORD_W-1:0]    result_TDATA,
  output logic [7:0]           result_TKEEP,
  output logic                 result_TVALID,
  input  logic                 result_TREADY,
  output logic                 result_TLAST,
  output logic                 busy,
  output logic                 timeout_err
`ifdef SNOOP_CTRL_AUTO_REARM_EN
  ,
  input  logic                 rearm
`endif
);

  localparam int unsigned TO_W = $clog2(COLLECT_TIMEOUT + 1);

  state_t               state;
  logic [WIN_WIDTH-1:0] win_cnt;
  logic [WIN_WIDTH-1:0] last_len;
  logic [TO_W-1:0]      to_cnt;
  beat_idx_t            beat;
  logic                 collect_en;
  result_beat_t         res_q;

  logic [RESULT_BEATS-1:0] tvalid_v, tready_v, take_v, captured_v;
  logic [WORD_W-1:0]       tdata_v [RESULT_BEATS];
  logic [WORD_W-1:0]       word_v  [RESULT_BEATS];

  logic [WIN_WIDTH-1:0] eff_len_c;
  logic [WORD_W-1:0]    first_word_c;
  beat_idx_t            beat_nxt_c;
  logic rearm_c, start_ok_c, last_hs_c, all_done_c, timeout_hit_c, clear_c, fill_c;

`ifdef SNOOP_CTRL_AUTO_REARM_EN
  assign rearm_c = rearm;
`else
  assign rearm_c = 1'b0;
`endif

  assign tvalid_v   = {packet_count_TVALID, flit_count_TVALID, cycle_count_TVALID};
  assign tdata_v[0] = cycle_count_TDATA;
  assign tdata_v[1] = flit_count_TDATA;
  assign tdata_v[2] = packet_count_TDATA;

  assign cycle_count_TREADY  = tready_v[0];
  assign flit_count_TREADY   = tready_v[1];
  assign packet_count_TREADY = tready_v[2];

  assign result_TDATA = res_q.data;
  assign result_TLAST = res_q.last;
  assign result_TKEEP = 8'hFF;

  assign eff_len_c     = (window_len == '0) ? WIN_WIDTH'(1) : window_len;
  assign start_ok_c    = (state == ST_IDLE) & start;
  assign last_hs_c     = (state == ST_EMIT) & result_TVALID & result_TREADY & (beat == LAST_BEAT);
  assign all_done_c    = &(captured_v | take_v);
  assign timeout_hit_c = (to_cnt == TO_W'(COLLECT_TIMEOUT - 1));
  assign fill_c        = (state == ST_COLLECT) & timeout_hit_c;
  assign clear_c       = start_ok_c | (last_hs_c & rearm_c);
  assign beat_nxt_c    = beat + beat_idx_t'(1);

  // Beat 0 is loaded on the same edge its slot may still be capturing or filling.
  assign first_word_c = take_v[0]     ? tdata_v[0] :
                        captured_v[0] ? word_v[0]  : TIMEOUT_FILL;

  genvar i;
  for (i = 0; i < int'(RESULT_BEATS); i++) begin : g_slot
    count_capture_slot u_slot (
      .clk        (clk),
      .areset     (areset),
      .clear      (clear_c),
      .collect_en (collect_en),
      .force_fill (fill_c),
      .tvalid     (tvalid_v[i]),
      .tdata      (tdata_v[i]),
      .tready_c   (tready_v[i]),
      .take_c     (take_v[i]),
      .captured   (captured_v[i]),
      .word       (word_v[i])
    );
  end

  // Sequencer: IDLE -> MEASURE -> COLLECT -> EMIT -> IDLE (or MEASURE on rearm).
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      win_cnt       <= '0;
      last_len      <= '0;
      to_cnt        <= '0;
      beat          <= '0;
      collect_en    <= 1'b0;
      measure       <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
      result_TVALID <= 1'b0;
      res_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_MEASURE;
            win_cnt     <= eff_len_c;
            last_len    <= eff_len_c;
            measure     <= 1'b1;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if ((win_cnt == WIN_WIDTH'(1)) || abort) begin
            state      <= ST_COLLECT;
            measure    <= 1'b0;
            collect_en <= 1'b1;
            to_cnt     <= '0;
          end else begin
            win_cnt <= win_cnt - WIN_WIDTH'(1);
          end
        end
        ST_COLLECT: begin
          if (all_done_c || timeout_hit_c) begin
            state         <= ST_EMIT;
            collect_en    <= 1'b0;
            beat          <= '0;
            result_TVALID <= 1'b1;
            res_q.data    <= first_word_c;
            res_q.last    <= 1'b0;
            if (!all_done_c) timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_EMIT: begin
          if (result_TVALID && result_TREADY) begin
            if (beat == LAST_BEAT) begin
              result_TVALID <= 1'b0;
              res_q.last    <= 1'b0;
              if (rearm_c) begin
                state   <= ST_MEASURE;
                win_cnt <= last_len;
                measure <= 1'b1;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              beat       <= beat_nxt_c;
              res_q.data <= word_v[beat_nxt_c];
              res_q.last <= (beat_nxt_c == LAST_BEAT);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_window_ctrl.sv
// Randomized self-checking bench for snoop_window_ctrl; SNOOP_CTRL_AUTO_REARM_EN enables the rearm scenario.
module tb_snoop_window_ctrl;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        areset;
  logic        start;
  logic        abort;
  logic [31:0] window_len;
  logic        measure;
  logic [63:0] wd [3];
  logic [2:0]  vld;
  logic        rdy0, rdy1, rdy2;
  logic [2:0]  rdy;
  logic [63:0] result_TDATA;
  logic [7:0]  result_TKEEP;
  logic        result_TVALID;
  logic        result_TREADY;
  logic        result_TLAST;
  logic        busy;
  logic        timeout_err;
`ifdef SNOOP_CTRL_AUTO_REARM_EN
  logic        rearm;
`endif

  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          last_to  = 1'b0;

  assign rdy = {rdy2, rdy1, rdy0};

  snoop_window_ctrl dut (
    .clk                 (clk),
    .areset              (areset),
    .start               (start),
    .window_len          (window_len),
    .abort               (abort),
    .measure             (measure),
    .cycle_count_TDATA   (wd[0]),
    .cycle_count_TVALID  (vld[0]),
    .cycle_count_TREADY  (rdy0),
    .flit_count_TDATA    (wd[1]),
    .flit_count_TVALID   (vld[1]),
    .flit_count_TREADY   (rdy1),
    .packet_count_TDATA  (wd[2]),
    .packet_count_TVALID (vld[2]),
    .packet_count_TREADY (rdy2),
    .result_TDATA        (result_TDATA),
    .result_TKEEP        (result_TKEEP),
    .result_TVALID       (result_TVALID),
    .result_TREADY       (result_TREADY),
    .result_TLAST        (result_TLAST),
    .busy                (busy),
    .timeout_err         (timeout_err)
`ifdef SNOOP_CTRL_AUTO_REARM_EN
    ,
    .rearm               (rearm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full measurement record; called and returning on a falling edge.
  task automatic run_record(input int unsigned len, input int unsigned abort_k, input logic [2:0] give,
                            input bit fixed_words, input bit late0, input bit fixed_rdy,
                            input bit via_rearm, input bit rearm_after);
    int unsigned eff, mhigh, cexp, beats, guard;
    int unsigned d [3];
    logic [63:0] w [3];
    logic [63:0] exp_w [3];
    bit          taken [3];
    bit          pat [6];
    bit          to_exp, prev_stall, rdy_now, prev_last;
    logic [63:0] prev_data;

    pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    eff    = (len == 0) ? 1 : len;
    mhigh  = (abort_k != 0 && abort_k < eff) ? abort_k : eff;
    to_exp = (give != 3'b111);
    cexp   = 0;
    for (int i = 0; i < 3; i++) begin
      d[i] = $urandom_range(0, 63);
      if (late0 && i == 0) d[i] = 63;
      w[i] = {$urandom, $urandom};
      taken[i] = 1'b0;
      if (give[i] && d[i] + 1 > cexp) cexp = d[i] + 1;
    end
    if (fixed_words) begin
      w[0] = 64'd10;
      w[1] = 64'd7;
      w[2] = 64'd2;
    end
    if (to_exp) cexp = 64;
    for (int i = 0; i < 3; i++) exp_w[i] = give[i] ? w[i] : ALL_ONES;

    if (!via_rearm) begin
      start      = 1'b1;
      window_len = len;
      @(negedge clk);
      start = 1'b0;
    end

    // measure window: stray start/count words here must have no effect
    for (int unsigned k = 1; k <= mhigh; k++) begin
      check_eq("measure_on", 64'(measure), 64'(1));
      check_eq("busy_meas", 64'(busy), 64'(1));
      check_eq("tready_meas", 64'(rdy), 64'(0));
      if (k == 1) check_eq("terr_at_start", 64'(timeout_err), 64'(via_rearm ? last_to : 1'b0));
      abort      = (k == abort_k);
      start      = (k == 2);
      window_len = $urandom;
      vld        = 3'b111;
      for (int i = 0; i < 3; i++) wd[i] = {$urandom, $urandom};
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    vld   = 3'b000;

    for (int unsigned c = 0; c < cexp; c++) begin
      check_eq("measure_off", 64'(measure), 64'(0));
      check_eq("tvalid_collect", 64'(result_TVALID), 64'(0));
      check_eq("tready_collect", 64'(rdy), 64'({!taken[2], !taken[1], !taken[0]}));
      for (int i = 0; i < 3; i++) begin
        vld[i] = give[i] && c >= d[i] && !taken[i];
        wd[i]  = vld[i] ? w[i] : {$urandom, $urandom};
        if (vld[i] && rdy[i]) taken[i] = 1'b1;
      end
      abort = (c == 1);
      @(negedge clk);
    end
    vld   = 3'b000;
    abort = 1'b0;

    beats      = 0;
    guard      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    while (beats < 3 && guard < 64) begin
      check_eq("tvalid_emit", 64'(result_TVALID), 64'(1));
      check_eq("busy_emit", 64'(busy), 64'(1));
      if (prev_stall) begin
        check_eq("hold_data", result_TDATA, prev_data);
        check_eq("hold_last", 64'(result_TLAST), 64'(prev_last));
      end
      rdy_now       = fixed_rdy ? ((guard < 6) ? pat[guard] : 1'b1) : 1'($urandom_range(0, 1));
      start         = fixed_rdy && guard == 2;
      result_TREADY = rdy_now;
      prev_stall    = result_TVALID && !rdy_now;
      prev_data     = result_TDATA;
      prev_last     = result_TLAST;
      if (result_TVALID && rdy_now) begin
        check_eq($sformatf("beat%0d_data", beats), result_TDATA, exp_w[beats]);
        check_eq($sformatf("beat%0d_last", beats), 64'(result_TLAST), 64'(beats == 2));
        beats++;
`ifdef SNOOP_CTRL_AUTO_REARM_EN
        if (beats == 3) rearm = rearm_after;
`endif
      end
      guard++;
      @(negedge clk);
    end
    result_TREADY = 1'b0;
    start         = 1'b0;
`ifdef SNOOP_CTRL_AUTO_REARM_EN
    rearm = 1'b0;
`endif

    check_eq("beat_count", 64'(beats), 64'(3));
    check_eq("tvalid_after", 64'(result_TVALID), 64'(0));
    check_eq("timeout_err", 64'(timeout_err), 64'(to_exp));
    if (rearm_after) begin
      check_eq("rearm_measure", 64'(measure), 64'(1));
    end else begin
      check_eq("busy_after", 64'(busy), 64'(0));
      check_eq("measure_after", 64'(measure), 64'(0));
    end
    last_to = to_exp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  g;
    int unsigned l, a;

    areset        = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    window_len    = '0;
    vld           = 3'b000;
    result_TREADY = 1'b0;
    for (int i = 0; i < 3; i++) wd[i] = '0;
`ifdef SNOOP_CTRL_AUTO_REARM_EN
    rearm = 1'b0;
`endif
    repeat (3) @(negedge clk);

    check_eq("rst_measure", 64'(measure), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_terr", 64'(timeout_err), 64'(0));
    check_eq("rst_tvalid", 64'(result_TVALID), 64'(0));
    check_eq("rst_tlast", 64'(result_TLAST), 64'(0));
    check_eq("rst_tready", 64'(rdy), 64'(0));
    check_eq("rst_tdata", result_TDATA, 64'(0));
    check_eq("rst_tkeep", 64'(result_TKEEP), 64'(8'hFF));
    areset = 1'b0;
    @(negedge clk);

    run_record(10, 0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_record(0, 0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_record(100, 20, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_record(6, 0, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_record(4, 0, 3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // asynchronous reset in the middle of a window
    start      = 1'b1;
    window_len = 50;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_measure", 64'(measure), 64'(1));
    #2 areset = 1'b1;
    #1;
    check_eq("rst_async_measure", 64'(measure), 64'(0));
    check_eq("rst_async_busy", 64'(busy), 64'(0));
    @(negedge clk);
    areset = 1'b0;
    check_eq("rst_mid_tready", 64'(rdy), 64'(0));
    check_eq("rst_mid_tvalid", 64'(result_TVALID), 64'(0));
    @(negedge clk);
    run_record(7, 0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      l = $urandom_range(0, 40);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
      g = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
      run_record(l, a, g, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

`ifdef SNOOP_CTRL_AUTO_REARM_EN
    run_record(12, 0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_record(12, 0, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
